// File: rtl/dff_reg_arbiter_pkg.sv
// dff_reg_arbiter_pkg: FSM state encoding and hold-counter width
// shared by the arbitrated flip-flop register bank.
package dff_reg_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/dff_reg_arbiter_bank.sv
// dff_bank_en: WIDTH-bit D flip-flop bank, load enable, sync
// active-low clear. Ports: clk, rst_n, en, d -> q, qnot (= ~q).
module dff_bank_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

  assign qnot = ~q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: two-writer round-robin arbiter and write sequencer
// for one shared register. Ports: C, RE (sync, active-low), req0/1,
// d0/1 in; gnt0/1, Q, Qnot, done, busy out.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             C,
  input  logic             RE,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             done,
  output logic             busy
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  // set when requester 1 was the last one written
  logic             last;
  logic             last_n;
  logic             gnt0_n;
  logic             gnt1_n;
  logic             done_n;
  logic             load;
  logic             pick1;
  logic             own_req;
  logic [WIDTH-1:0] wdata;

  assign own_req = gnt1 ? req1 : req0;
  assign wdata   = gnt1 ? d1 : d0;
  // on a tie, requester 1 wins only if 0 was served last
  assign pick1   = req1 & (~req0 | ~last);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    gnt0_n  = gnt0;
    gnt1_n  = gnt1;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        gnt0_n = 1'b0;
        gnt1_n = 1'b0;
        if (req0 | req1) begin
          state_n = S_WRITE;
          gnt0_n  = ~pick1;
          gnt1_n  = pick1;
        end
      end
      S_WRITE: begin
        if (own_req) begin
          load    = 1'b1;
          done_n  = 1'b1;
          cnt_n   = CNT_W'(HOLD - 1);
          last_n  = gnt1;
          state_n = S_HOLD;
        end else begin
          state_n = S_IDLE;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt == '0 || !own_req) begin
          state_n = S_IDLE;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (!RE) begin
      state <= S_IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      gnt0  <= gnt0_n;
      gnt1  <= gnt1_n;
      done  <= done_n;
    end
  end

  dff_bank_en #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (C),
    .rst_n(RE),
    .en   (load),
    .d    (wdata),
    .q    (Q),
    .qnot (Qnot)
  );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed bench for HOLD=2 and HOLD=1 instances
// with a transaction-level model and hand-computed spot checks.
module tb_dff_reg_arbiter;

  localparam int W = 4;

  logic         C    = 1'b0;
  logic         RE   = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] d0   = '0;
  logic [W-1:0] d1   = '0;

  logic         g0 [2];
  logic         g1 [2];
  logic         dn [2];
  logic         bz [2];
  logic [W-1:0] q  [2];
  logic [W-1:0] qn [2];

  int nchk = 0;
  int nerr = 0;
  bit armed = 1'b0;

  // model: owner of the register (-1 none), cycles since grant,
  // last served requester, register value, done pulse
  int           own [2];
  int           age [2];
  int           lst [2];
  logic [W-1:0] mq  [2];
  logic         mdn [2];

  always #5 C = ~C;

  dff_reg_arbiter #(.WIDTH(W), .HOLD(2)) u0 (
    .C(C), .RE(RE), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(g0[0]), .gnt1(g1[0]),
    .Q(q[0]), .Qnot(qn[0]), .done(dn[0]), .busy(bz[0])
  );

  dff_reg_arbiter #(.WIDTH(W), .HOLD(1)) u1 (
    .C(C), .RE(RE), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(g0[1]), .gnt1(g1[1]),
    .Q(q[1]), .Qnot(qn[1]), .done(dn[1]), .busy(bz[1])
  );

  function automatic int hold_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, int i,
                     logic [W-1:0] act, logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s u%0d t=%0t: got %b want %b",
               nm, i, $time, act, exp);
    end
  endtask

  task automatic chk_u(int i, logic eg0, logic eg1,
                       logic ed, logic eb, logic [W-1:0] eq);
    chk("lit_gnt0", i, {3'b000, g0[i]}, {3'b000, eg0});
    chk("lit_gnt1", i, {3'b000, g1[i]}, {3'b000, eg1});
    chk("lit_done", i, {3'b000, dn[i]}, {3'b000, ed});
    chk("lit_busy", i, {3'b000, bz[i]}, {3'b000, eb});
    chk("lit_Q", i, q[i], eq);
    chk("lit_Qnot", i, qn[i], ~eq);
  endtask

  always @(posedge C) begin
    for (int i = 0; i < 2; i++) begin
      logic rq;
      if (!RE) begin
        own[i] = -1;
        age[i] = 0;
        lst[i] = 1;
        mq[i]  = '0;
        mdn[i] = 1'b0;
      end else begin
        mdn[i] = 1'b0;
        if (own[i] < 0) begin
          if (req0 || req1) begin
            if (req0 && req1) own[i] = 1 - lst[i];
            else own[i] = req1 ? 1 : 0;
            age[i] = 0;
          end
        end else begin
          rq = (own[i] == 1) ? req1 : req0;
          if (!rq) begin
            own[i] = -1;
          end else if (age[i] == 0) begin
            mq[i]  = (own[i] == 1) ? d1 : d0;
            mdn[i] = 1'b1;
            lst[i] = own[i];
            age[i] = 1;
          end else if (age[i] == hold_of(i)) begin
            own[i] = -1;
          end else begin
            age[i]++;
          end
        end
      end
    end
    if (!RE) armed = 1'b1;
  end

  always @(negedge C) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk("gnt0", i, {3'b000, g0[i]},
            {3'b000, own[i] == 0});
        chk("gnt1", i, {3'b000, g1[i]},
            {3'b000, own[i] == 1});
        chk("busy", i, {3'b000, bz[i]},
            {3'b000, own[i] >= 0});
        chk("done", i, {3'b000, dn[i]}, {3'b000, mdn[i]});
        chk("Q", i, q[i], mq[i]);
        chk("Qnot", i, qn[i], ~mq[i]);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge C);
  endtask

  task automatic do_reset();
    RE   = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    RE = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset held with a pending request
    req0 = 1'b1;
    d0   = 4'b1111;
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b0000);
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b0000);

    // single write, HOLD=2; d0 change in HOLD ignored
    RE = 1'b1;
    d0 = 4'b1010;
    tick();
    chk_u(0, 1, 0, 0, 1, 4'b0000);
    tick();
    chk_u(0, 1, 0, 1, 1, 4'b1010);
    chk_u(1, 1, 0, 1, 1, 4'b1010);
    d0 = 4'b0111;
    tick();
    chk_u(0, 1, 0, 0, 1, 4'b1010);
    chk_u(1, 0, 0, 0, 0, 4'b1010);
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b1010);
    req0 = 1'b0;
    tick(3);

    // tie and alternation
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 4'b0011;
    d1   = 4'b1100;
    tick();
    chk_u(0, 1, 0, 0, 1, 4'b0000);
    tick();
    chk_u(0, 1, 0, 1, 1, 4'b0011);
    tick(2);
    chk_u(0, 0, 0, 0, 0, 4'b0011);
    chk_u(1, 0, 1, 0, 1, 4'b0011);
    tick();
    chk_u(0, 0, 1, 0, 1, 4'b0011);
    tick();
    chk_u(0, 0, 1, 1, 1, 4'b1100);
    tick(3);
    chk_u(0, 1, 0, 0, 1, 4'b1100);
    tick();
    chk_u(0, 1, 0, 1, 1, 4'b0011);
    req0 = 1'b0;
    req1 = 1'b0;
    tick(4);

    // abort in WRITE keeps the pointer
    do_reset();
    req1 = 1'b1;
    d1   = 4'b0110;
    tick();
    chk_u(0, 0, 1, 0, 1, 4'b0000);
    req1 = 1'b0;
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b0000);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk_u(0, 1, 0, 0, 1, 4'b0000);
    req0 = 1'b0;
    req1 = 1'b0;
    tick(3);

    // early release in HOLD
    do_reset();
    req0 = 1'b1;
    d0   = 4'b1001;
    tick(2);
    chk_u(0, 1, 0, 1, 1, 4'b1001);
    req0 = 1'b0;
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b1001);
    tick(2);

    // reset during HOLD
    do_reset();
    req1 = 1'b1;
    d1   = 4'b1110;
    tick(2);
    chk_u(0, 0, 1, 1, 1, 4'b1110);
    RE = 1'b0;
    tick();
    chk_u(0, 0, 0, 0, 0, 4'b0000);
    RE   = 1'b1;
    req1 = 1'b0;
    tick(2);

    // HOLD=1 instance, single req1
    do_reset();
    req1 = 1'b1;
    d1   = 4'b0101;
    tick();
    chk_u(1, 0, 1, 0, 1, 4'b0000);
    tick();
    chk_u(1, 0, 1, 1, 1, 4'b0101);
    tick();
    chk_u(1, 0, 0, 0, 0, 4'b0101);
    req1 = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

endmodule
